// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions the three raw buttons, runs the IDLE/RUN/PAUSE/LAP
// state machine and divides the clock down to one-cycle count-advance strobes.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic       start_pause,
  input  logic       clear_btn,
  input  logic       lap_btn,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int unsigned PS_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  localparam int unsigned B_START = 0;
  localparam int unsigned B_CLEAR = 1;
  localparam int unsigned B_LAP   = 2;
  localparam int unsigned N_BTN   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  logic [N_BTN-1:0] w_btn_raw;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_db_lvl;
  logic [N_BTN-1:0] r_press;
  logic [DB_W-1:0]  r_db_cnt [N_BTN];

  state_t           r_state;
  state_t           w_next;
  logic             w_sel_clr;
  logic             w_sel_start;
  logic             w_sel_lap;
  logic             w_clr_acc;
  logic             r_cnt_clr;

  logic [PS_W-1:0]  r_presc;
  logic             w_counting;
  logic             w_wrap;
  logic             r_cnt_en;

  assign w_btn_raw = {lap_btn, clear_btn, start_pause};

  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // The press pulse is raised on the same edge the debounced level falls, so it is
  // high exactly during the first cycle of the new low level.
  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_db_lvl <= '1;
      r_press  <= '0;
    end else begin
      r_press <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_db_lvl[i] <= r_sync2[i];
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_sel_clr   = r_press[B_CLEAR];
    w_sel_start = r_press[B_START] & ~r_press[B_CLEAR];
    w_sel_lap   = r_press[B_LAP] & ~r_press[B_START] & ~r_press[B_CLEAR];
  end

  always_comb begin
    w_next    = r_state;
    w_clr_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_clr) begin
          w_clr_acc = 1'b1;
        end else if (w_sel_start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_sel_start) begin
          w_next = PAUSE;
        end else if (w_sel_lap) begin
          w_next = LAP;
        end
      end
      LAP: begin
        if (w_sel_start) begin
          w_next = PAUSE;
        end else if (w_sel_lap) begin
          w_next = RUN;
        end
      end
      PAUSE: begin
        if (w_sel_clr) begin
          w_next    = IDLE;
          w_clr_acc = 1'b1;
        end else if (w_sel_start) begin
          w_next = RUN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt_clr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt_clr <= w_clr_acc;
    end
  end

  // Prescaler decisions use the pre-transition state, so a wrap on a RUN->PAUSE
  // press cycle still produces its tick.
  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_wrap     = w_counting && (r_presc == PS_LAST);

  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      r_presc  <= '0;
      r_cnt_en <= 1'b0;
    end else begin
      r_cnt_en <= w_wrap;
      if (r_state == IDLE) begin
        r_presc <= '0;
      end else if (w_counting) begin
        r_presc <= w_wrap ? '0 : r_presc + PS_W'(1);
      end
    end
  end

  assign cnt_en   = r_cnt_en;
  assign cnt_clr  = r_cnt_clr;
  assign lap_hold = (r_state == LAP);
  assign state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: expected state changes, clears and ticks are queued
// with their cycle numbers when a button is driven and matched as the DUT emits them.
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int LAT = 7;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  typedef struct {
    logic [1:0] st;
    int         cyc;
  } st_exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sp    = 1'b1;
  logic       cb    = 1'b1;
  logic       lb    = 1'b1;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic [1:0] state;

  int cyc    = 0;
  int n_pass = 0;
  int n_tot  = 0;
  int R, S, U, R3;

  st_exp_t    q_st[$];
  int         q_tick[$];
  int         q_clr[$];
  logic [1:0] prev_state = 2'b00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(
    .TICK_DIV    (10),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk_50Mhz  (clk),
    .reset      (rst_n),
    .start_pause(sp),
    .clear_btn  (cb),
    .lap_btn    (lb),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .lap_hold   (lap_hold),
    .state      (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic c, input logic l);
    if (s) sp = 1'b0;
    if (c) cb = 1'b0;
    if (l) lb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    sp = 1'b1;
    cb = 1'b1;
    lb = 1'b1;
  endtask

  task automatic push_state(input logic [1:0] st, input int c);
    st_exp_t e;
    e.st  = st;
    e.cyc = c;
    q_st.push_back(e);
  endtask

  always @(negedge clk) begin
    st_exp_t e;
    if (rst_n !== 1'b1) begin
      prev_state = state;
    end else begin
      if (state !== prev_state) begin
        chk("state_change_expected", (q_st.size() > 0) ? 1 : 0, 1);
        if (q_st.size() > 0) begin
          e = q_st.pop_front();
          chk("state_value", state, e.st);
          chk("state_cycle", cyc, e.cyc);
          chk("lap_hold", lap_hold, (e.st == S_LAP) ? 1 : 0);
        end
        prev_state = state;
      end
      if (cnt_clr !== 1'b0) begin
        chk("cnt_clr_expected", (q_clr.size() > 0) ? 1 : 0, 1);
        if (q_clr.size() > 0) chk("cnt_clr_cycle", cyc, q_clr.pop_front());
      end
      if (cnt_en !== 1'b0) begin
        chk("cnt_en_expected", (q_tick.size() > 0) ? 1 : 0, 1);
        if (q_tick.size() > 0) chk("cnt_en_cycle", cyc, q_tick.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $error("FAIL timeout: observed cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", state, S_IDLE);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_lap_hold", lap_hold, 0);
    wait_until(5);
    rst_n = 1'b1;

    // bounce shorter than the debounce window, then lap in IDLE: nothing accepted
    wait_until(10);
    for (int i = 0; i < 10; i++) begin
      sp = ~sp;
      repeat (2) @(posedge clk);
      #1;
    end
    wait_until(40);
    press(1'b0, 1'b0, 1'b1);
    wait_until(58);
    chk("idle_after_bounce", state, S_IDLE);

    // clear in IDLE still pulses cnt_clr
    wait_until(60);
    q_clr.push_back(60 + LAT);
    press(1'b0, 1'b1, 1'b0);

    // start from IDLE; ticks every TD cycles; clear ignored in RUN
    wait_until(90);
    R = 90 + LAT;
    push_state(S_RUN, R);
    for (int k = 1; k <= 3; k++) q_tick.push_back(R + k * TD);
    press(1'b1, 1'b0, 1'b0);
    wait_until(R + 5);
    press(1'b0, 1'b1, 1'b0);

    // pause after 32 running cycles, lap ignored in PAUSE, resume completes the period
    wait_until(R + 25);
    S = R + 25 + LAT;
    push_state(S_PAUSE, S);
    press(1'b1, 1'b0, 1'b0);
    wait_until(S + 5);
    press(1'b0, 1'b0, 1'b1);
    wait_until(R + 55);
    U = R + 55 + LAT;
    push_state(S_RUN, U);
    for (int k = 0; k < 6; k++) q_tick.push_back(U + (TD - ((S - R) % TD)) + k * TD);
    press(1'b1, 1'b0, 1'b0);

    // lap in and out while ticks keep their period
    wait_until(U + 12);
    push_state(S_LAP, U + 12 + LAT);
    press(1'b0, 1'b0, 1'b1);
    wait_until(U + 42);
    push_state(S_RUN, U + 42 + LAT);
    press(1'b0, 1'b0, 1'b1);

    // pause, then clear and start in the same cycle: clear wins
    wait_until(U + 53);
    push_state(S_PAUSE, U + 53 + LAT);
    press(1'b1, 1'b0, 1'b0);
    wait_until(U + 70);
    push_state(S_IDLE, U + 70 + LAT);
    q_clr.push_back(U + 70 + LAT);
    press(1'b1, 1'b1, 1'b0);

    // run, enter LAP, then reset between clock edges
    wait_until(U + 97);
    R3 = U + 97 + LAT;
    push_state(S_RUN, R3);
    q_tick.push_back(R3 + TD);
    press(1'b1, 1'b0, 1'b0);
    wait_until(R3 + 5);
    push_state(S_LAP, R3 + 5 + LAT);
    press(1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, S_IDLE);
    chk("async_rst_lap_hold", lap_hold, 0);
    chk("async_rst_cnt_en", cnt_en, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_until(R3 + 55);
    chk("post_reset_state", state, S_IDLE);

    chk("state_queue_drained", q_st.size(), 0);
    chk("tick_queue_drained", q_tick.size(), 0);
    chk("clr_queue_drained", q_clr.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
